// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller:
// FSM state encodings, writeback-select codes, the canonical NOP
// and a helper that matches one source operand against a destination.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_e;

    localparam logic [1:0]  DTR_ALU  = 2'b00;
    localparam logic [1:0]  DTR_MEM  = 2'b01;
    localparam logic [1:0]  DTR_PC4  = 2'b10;

    localparam logic [31:0] NOP_INST = 32'h00000013;

    // True when a used source operand reads a non-x0 register about to be written.
    function automatic logic src_matches(input logic [4:0] src_idx,
                                         input logic       src_used,
                                         input logic [4:0] dst_idx);
        return src_used && (dst_idx != 5'd0) && (src_idx == dst_idx);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status inputs, pipeline-register
// control pins and the performance-counter readouts.
// master = pipeline side, slave = the controller.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic [4:0]       exe_written_reg;
    logic             exe_reg_write;
    logic [1:0]       exe_data_to_reg;
    logic             exe_branch_valid;
    logic             exe_mispredict;
    logic             mem_req;
    logic             mem_ready;

    logic             pc_ce;
    logic             if_id_ce;
    logic             if_id_cstall;
    logic             id_exe_ce;
    logic             id_exe_dstall;
    logic             id_exe_cstall;
    logic             exe_mem_ce;
    logic             mem_wb_ce;
    logic [1:0]       busy_state;

    logic [CNT_W-1:0] perf_bubbles;
    logic [CNT_W-1:0] perf_flush_cycles;
    logic [CNT_W-1:0] perf_freeze_cycles;

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               exe_written_reg, exe_reg_write, exe_data_to_reg,
               exe_branch_valid, exe_mispredict, mem_req, mem_ready,
        input  pc_ce, if_id_ce, if_id_cstall, id_exe_ce, id_exe_dstall,
               id_exe_cstall, exe_mem_ce, mem_wb_ce, busy_state,
               perf_bubbles, perf_flush_cycles, perf_freeze_cycles
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               exe_written_reg, exe_reg_write, exe_data_to_reg,
               exe_branch_valid, exe_mispredict, mem_req, mem_ready,
        output pc_ce, if_id_ce, if_id_cstall, id_exe_ce, id_exe_dstall,
               id_exe_cstall, exe_mem_ce, mem_wb_ce, busy_state,
               perf_bubbles, perf_flush_cycles, perf_freeze_cycles
    );

endinterface

// File: rtl/pipeline_hazard_perf_counters.sv
// Three saturating event counters (bubbles, flush cycles, freeze cycles).
// Only instantiated when HAZARD_PERF_CNT_EN is defined.
module hazard_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_bubble,
    input  logic             i_flush,
    input  logic             i_freeze,
    output logic [CNT_W-1:0] o_bubbles,
    output logic [CNT_W-1:0] o_flush_cycles,
    output logic [CNT_W-1:0] o_freeze_cycles
);
    logic [2:0]       w_evt;
    logic [CNT_W-1:0] r_cnt [3];

    assign w_evt = {i_freeze, i_flush, i_bubble};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt
            // Count one per event cycle, sticking at all-ones.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    r_cnt[gi] <= '0;
                else if (w_evt[gi] && (r_cnt[gi] != {CNT_W{1'b1}}))
                    r_cnt[gi] <= r_cnt[gi] + 1'b1;
            end
        end
    endgenerate

    assign o_bubbles       = r_cnt[0];
    assign o_flush_cycles  = r_cnt[1];
    assign o_freeze_cycles = r_cnt[2];

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage RV32I pipeline.
// Priority: data-memory freeze > mispredict flush > load-use bubble.
// Optional macro HAZARD_PERF_CNT_EN adds saturating performance counters;
// without it the perf outputs are tied to zero.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.slave hz
);
    hz_state_e  r_state;
    hz_state_e  w_state_next;
    logic [2:0] r_fcnt;
    logic [2:0] w_fcnt_next;
    logic       r_ret_flush;
    logic       w_ret_flush_next;

    logic       w_freeze;
    logic       w_mispredict;
    logic       w_load_use;
    logic       w_bubble;

    logic       w_pc_ce, w_if_id_ce, w_if_id_cstall;
    logic       w_id_exe_ce, w_id_exe_dstall, w_id_exe_cstall;
    logic       w_exe_mem_ce, w_mem_wb_ce;

    assign w_freeze     = hz.mem_req && !hz.mem_ready;
    assign w_mispredict = hz.exe_branch_valid && hz.exe_mispredict && !w_freeze;
    assign w_load_use   = hz.exe_reg_write && (hz.exe_data_to_reg == DTR_MEM) &&
                          (src_matches(hz.id_rs1, hz.id_rs1_used, hz.exe_written_reg) ||
                           src_matches(hz.id_rs2, hz.id_rs2_used, hz.exe_written_reg));
    // A bubble is only really inserted when nothing of higher priority wins.
    assign w_bubble     = (r_state == RUN) && !w_freeze && !w_mispredict && w_load_use;

    // State, flush countdown and freeze-return flag; reset aborts any sequence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= RUN;
            r_fcnt      <= 3'd0;
            r_ret_flush <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_fcnt      <= w_fcnt_next;
            r_ret_flush <= w_ret_flush_next;
        end
    end

    // Next-state and control-pin decode; hazards act in the cycle they appear.
    always_comb begin
        w_state_next     = r_state;
        w_fcnt_next      = r_fcnt;
        w_ret_flush_next = r_ret_flush;
        w_pc_ce          = 1'b1;
        w_if_id_ce       = 1'b1;
        w_id_exe_ce      = 1'b1;
        w_exe_mem_ce     = 1'b1;
        w_mem_wb_ce      = 1'b1;
        w_if_id_cstall   = 1'b0;
        w_id_exe_dstall  = 1'b0;
        w_id_exe_cstall  = 1'b0;

        if (w_freeze) begin
            // Whole pipe holds; remember whether a flush was interrupted.
            w_pc_ce      = 1'b0;
            w_if_id_ce   = 1'b0;
            w_id_exe_ce  = 1'b0;
            w_exe_mem_ce = 1'b0;
            w_mem_wb_ce  = 1'b0;
            w_state_next = MEM_WAIT;
            if (r_state != MEM_WAIT)
                w_ret_flush_next = (r_state == FLUSH);
        end else begin
            unique case (r_state)
                RUN: begin
                    if (w_mispredict) begin
                        w_if_id_cstall  = 1'b1;
                        w_id_exe_cstall = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            w_fcnt_next  = 3'(FLUSH_CYCLES - 1);
                            w_state_next = FLUSH;
                        end
                    end else if (w_bubble) begin
                        w_pc_ce         = 1'b0;
                        w_if_id_ce      = 1'b0;
                        w_id_exe_dstall = 1'b1;
                    end
                end
                FLUSH: begin
                    // Wrong-path instructions: mispredict/load-use ignored here.
                    w_if_id_cstall  = 1'b1;
                    w_id_exe_cstall = 1'b1;
                    if (r_fcnt <= 3'd1) begin
                        w_fcnt_next  = 3'd0;
                        w_state_next = RUN;
                    end else begin
                        w_fcnt_next  = r_fcnt - 3'd1;
                    end
                end
                MEM_WAIT: begin
                    w_state_next = (r_ret_flush && (r_fcnt != 3'd0)) ? FLUSH : RUN;
                end
                default: begin
                    w_state_next = RUN;
                end
            endcase
        end
    end

    assign hz.pc_ce         = w_pc_ce;
    assign hz.if_id_ce      = w_if_id_ce;
    assign hz.if_id_cstall  = w_if_id_cstall;
    assign hz.id_exe_ce     = w_id_exe_ce;
    assign hz.id_exe_dstall = w_id_exe_dstall;
    assign hz.id_exe_cstall = w_id_exe_cstall;
    assign hz.exe_mem_ce    = w_exe_mem_ce;
    assign hz.mem_wb_ce     = w_mem_wb_ce;
    assign hz.busy_state    = r_state;

`ifdef HAZARD_PERF_CNT_EN
    logic w_cstall_any;
    assign w_cstall_any = w_if_id_cstall || w_id_exe_cstall;

    hazard_perf_counters #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk             (clk),
        .rst             (rst),
        .i_bubble        (w_bubble),
        .i_flush         (w_cstall_any),
        .i_freeze        (w_freeze),
        .o_bubbles       (hz.perf_bubbles),
        .o_flush_cycles  (hz.perf_flush_cycles),
        .o_freeze_cycles (hz.perf_freeze_cycles)
    );
`else
    assign hz.perf_bubbles       = '0;
    assign hz.perf_flush_cycles  = '0;
    assign hz.perf_freeze_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl (FLUSH_CYCLES=2).
// Each driven cycle pushes its expected control vector; the negedge
// monitor pops and compares. Vector bit order:
// {pc_ce, if_id_ce, if_id_cstall, id_exe_ce, id_exe_dstall,
//  id_exe_cstall, exe_mem_ce, mem_wb_ce, busy_state[1:0]}
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 32;

    localparam logic [9:0] E_RUN      = 10'b11_0_1_0_0_11_00;
    localparam logic [9:0] E_BUBBLE   = 10'b00_0_1_1_0_11_00;
    localparam logic [9:0] E_MISP     = 10'b11_1_1_0_1_11_00;
    localparam logic [9:0] E_FLUSH    = 10'b11_1_1_0_1_11_01;
    localparam logic [9:0] E_FRZ_RUN  = 10'b00_0_0_0_0_00_00;
    localparam logic [9:0] E_FRZ_FL   = 10'b00_0_0_0_0_00_01;
    localparam logic [9:0] E_FRZ_WAIT = 10'b00_0_0_0_0_00_10;
    localparam logic [9:0] E_RELEASE  = 10'b11_0_1_0_0_11_10;

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_errors = 0;

    logic [9:0] exp_q [$];
    string      tag_q [$];

    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hif ();

    pipeline_hazard_ctrl #(
        .FLUSH_CYCLES (2),
        .CNT_W        (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hif.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_result(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    function automatic logic [9:0] ctrl_vec();
        return {hif.pc_ce, hif.if_id_ce, hif.if_id_cstall, hif.id_exe_ce,
                hif.id_exe_dstall, hif.id_exe_cstall, hif.exe_mem_ce,
                hif.mem_wb_ce, hif.busy_state};
    endfunction

    task automatic set_inputs(input logic [4:0] rs1, input logic rs1u,
                              input logic [4:0] rs2, input logic rs2u,
                              input logic [4:0] wr, input logic rw, input logic [1:0] dtr,
                              input logic bv, input logic mp,
                              input logic mreq, input logic mrdy);
        hif.id_rs1           = rs1;
        hif.id_rs1_used      = rs1u;
        hif.id_rs2           = rs2;
        hif.id_rs2_used      = rs2u;
        hif.exe_written_reg  = wr;
        hif.exe_reg_write    = rw;
        hif.exe_data_to_reg  = dtr;
        hif.exe_branch_valid = bv;
        hif.exe_mispredict   = mp;
        hif.mem_req          = mreq;
        hif.mem_ready        = mrdy;
    endtask

    // One driven cycle: apply stimulus after the edge, queue its expectation.
    task automatic drive(input string tag,
                         input logic [4:0] rs1, input logic rs1u,
                         input logic [4:0] rs2, input logic rs2u,
                         input logic [4:0] wr, input logic rw, input logic [1:0] dtr,
                         input logic bv, input logic mp,
                         input logic mreq, input logic mrdy,
                         input logic [9:0] exp);
        @(posedge clk);
        #1;
        set_inputs(rs1, rs1u, rs2, rs2u, wr, rw, dtr, bv, mp, mreq, mrdy);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
    endtask

    task automatic idle(input string tag, input logic [9:0] exp);
        drive(tag, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, exp);
    endtask

    // Monitor: compare the oldest expectation mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            check_result(tag_q.pop_front(), {22'd0, ctrl_vec()}, {22'd0, exp_q.pop_front()});
        end
    end

    initial begin
        rst = 1'b1;
        set_inputs(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        check_result("reset_ctrl", {22'd0, ctrl_vec()}, {22'd0, E_RUN});
        check_result("reset_perf_b", hif.perf_bubbles, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        idle("idle", E_RUN);
        //     tag            rs1   u    rs2   u    wr    rw   dtr    bv   mp   mreq mrdy  expected
        drive("lu_rs2",     5'd0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, E_BUBBLE);
        idle("after_bubble", E_RUN);
        drive("lu_x0",      5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, E_RUN);
        drive("lu_unused",  5'd0, 1'b0, 5'd5, 1'b0, 5'd5, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, E_RUN);
        drive("lu_rs1",     5'd7, 1'b1, 5'd3, 1'b1, 5'd7, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, E_BUBBLE);
        drive("alu_no_lu",  5'd7, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, E_RUN);
        drive("no_wr_lu",   5'd7, 1'b1, 5'd0, 1'b0, 5'd7, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, E_RUN);
        drive("misp",       5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, E_MISP);
        idle("flush2", E_FLUSH);
        idle("after_flush", E_RUN);
        drive("misp_unqual",5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, E_RUN);
        drive("misp_and_lu",5'd0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, E_MISP);
        drive("flush_ign",  5'd9, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, E_FLUSH);
        idle("after_flush2", E_RUN);
        drive("misp_b",     5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, E_MISP);
        drive("frz_in_fl1", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, E_FRZ_FL);
        drive("frz_in_fl2", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, E_FRZ_WAIT);
        drive("frz_in_fl3", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, E_FRZ_WAIT);
        drive("rel_to_fl",  5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, E_RELEASE);
        idle("fl_remaining", E_FLUSH);
        idle("fl_done", E_RUN);
        drive("mem_hit",    5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, E_RUN);
        drive("frz_beats",  5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0, E_FRZ_RUN);
        drive("frz_run2",   5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, E_FRZ_WAIT);
        drive("rel_to_run", 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, E_RELEASE);
        idle("run_again", E_RUN);
        drive("frz_pre_rst",5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, E_FRZ_RUN);
        drive("frz_wait_rst",5'd0,1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, E_FRZ_WAIT);

        // Mid-cycle, still in MEM_WAIT: inspect counters, then reset asynchronously.
        @(negedge clk);
        #1;
`ifdef HAZARD_PERF_CNT_EN
        check_result("perf_bubbles", hif.perf_bubbles, 32'd2);
        check_result("perf_flush", hif.perf_flush_cycles, 32'd6);
        check_result("perf_freeze", hif.perf_freeze_cycles, 32'd6);
`endif
        rst = 1'b1;
        #1;
        check_result("rst_async_state", {30'd0, hif.busy_state}, 32'd0);
        set_inputs(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check_result("rst_idle_ctrl", {22'd0, ctrl_vec()}, {22'd0, E_RUN});
        check_result("rst_perf_b", hif.perf_bubbles, 32'd0);
        check_result("rst_perf_f", hif.perf_flush_cycles, 32'd0);
        check_result("rst_perf_z", hif.perf_freeze_cycles, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        idle("post_rst", E_RUN);
        drive("misp_post",  5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, E_MISP);
        idle("flush_post", E_FLUSH);
        idle("run_post", E_RUN);

        @(negedge clk);
        #1;
        check_result("sb_drain", exp_q.size(), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
        check_result("end_perf_b", hif.perf_bubbles, 32'd0);
        check_result("end_perf_f", hif.perf_flush_cycles, 32'd2);
        check_result("end_perf_z", hif.perf_freeze_cycles, 32'd0);
`else
        check_result("end_perf_b", hif.perf_bubbles, 32'd0);
        check_result("end_perf_f", hif.perf_flush_cycles, 32'd0);
        check_result("end_perf_z", hif.perf_freeze_cycles, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
